// File: rtl/mem_handshake_ctrl.sv
// Multi-port memory handshake controller: records per-port completions within a pipeline step
// and holds a global stall until every requested port has returned. Optional timeout: MEM_TIMEOUT_EN.

module mem_handshake_lane (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic valid,
    input  logic load,
    input  logic clr,
    output logic issue,
    output logic port_done,
    output logic done
);
    logic hit;

    assign hit       = req & valid;
    assign issue     = req & ~done;
    assign port_done = ~req | done | valid;

    // load starts a fresh step (nothing recorded yet); otherwise completions accumulate
    always_ff @(posedge clk) begin
        if (!rst)      done <= 1'b0;
        else if (clr)  done <= 1'b0;
        else if (load) done <= hit;
        else           done <= done | hit;
    end
endmodule

module mem_handshake_ctrl #(
    parameter int NUM_PORTS   = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] valid,
    output logic [NUM_PORTS-1:0] issue,
    output logic                 stall,
    output logic [NUM_PORTS-1:0] done_mask,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic                 timeout_err
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] port_done;
    logic                 all_done;
    logic                 load;

    assign all_done = &port_done;
    assign stall    = ~all_done;
    assign load     = (state_q == S_IDLE);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        mem_handshake_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .req       (req[i]),
            .valid     (valid[i]),
            .load      (load),
            .clr       (all_done),
            .issue     (issue[i]),
            .port_done (port_done[i]),
            .done      (done_mask[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!all_done) state_d = S_WAIT;
            S_WAIT:  if (all_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)                            stall_cnt <= '0;
        else if (stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
    end

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_nxt;

    assign to_nxt = (to_cnt == CNT_MAX) ? to_cnt : to_cnt + 1'b1;

    // flag rises on the edge where the consecutive-stall run reaches the limit
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (stall) begin
            to_cnt <= to_nxt;
            if (to_nxt >= CNT_W'(TIMEOUT_CYC)) timeout_err <= 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Scoreboard bench for mem_handshake_ctrl: driver pushes model predictions, monitor pops and checks.
module tb_mem_handshake_ctrl;
    localparam int NP = 2;
    localparam int CW = 5;
    localparam int TO = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req, valid;
    logic [NP-1:0] issue, done_mask;
    logic          stall, timeout_err;
    logic [CW-1:0] stall_cnt;

    mem_handshake_ctrl #(.NUM_PORTS(NP), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .valid(valid), .issue(issue), .stall(stall),
        .done_mask(done_mask), .stall_cnt(stall_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          stall;
        logic [NP-1:0] issue;
        logic [NP-1:0] dm;
        logic [CW-1:0] cnt;
        logic          terr;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // reference: set of ports that have finished in the current step, plus counters
    logic [NP-1:0] m_done;
    int            m_cnt, m_run;
    bit            m_terr;
    bit            m_known = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit outstanding(input logic [NP-1:0] r, input logic [NP-1:0] v);
        bit any = 1'b0;
        for (int p = 0; p < NP; p++)
            if (r[p] && !m_done[p] && !v[p]) any = 1'b1;
        return any;
    endfunction

    task automatic step(input logic r, input logic [NP-1:0] rq, input logic [NP-1:0] vl);
        exp_t e;
        bit   st;
        rst = r; req = rq; valid = vl;
        st = outstanding(rq, vl);
        if (m_known) begin
            e.stall = st;
            for (int p = 0; p < NP; p++) e.issue[p] = rq[p] && !m_done[p];
            e.dm   = m_done;
            e.cnt  = CW'(m_cnt);
`ifdef MEM_TIMEOUT_EN
            e.terr = m_terr;
`else
            e.terr = 1'b0;
`endif
            q.push_back(e);
        end
        @(posedge clk);
        if (!r) begin
            m_done = '0; m_cnt = 0; m_run = 0; m_terr = 1'b0; m_known = 1'b1;
        end else if (m_known) begin
            if (!st) m_done = '0;
            else     m_done = m_done | (rq & vl);
            if (st) begin
                if (m_cnt < CMAX) m_cnt++;
                if (m_run < CMAX) m_run++;
                if (m_run >= TO) m_terr = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", int'(stall), int'(e.stall));
                chk("issue", int'(issue), int'(e.issue));
                chk("done_mask", int'(done_mask), int'(e.dm));
                chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
                chk("timeout_err", int'(timeout_err), int'(e.terr));
            end
        end
    end

    initial begin : driver
        rst = 1'b0; req = '0; valid = '0;
        @(posedge clk); #1;
        step(1'b0, 2'b00, 2'b00);
        step(1'b0, 2'b11, 2'b00);
        // same-cycle completion, split completion, spurious valid, reset mid-step
        step(1'b1, 2'b11, 2'b11);
        step(1'b1, 2'b11, 2'b01);
        step(1'b1, 2'b11, 2'b00);
        step(1'b1, 2'b11, 2'b10);
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b10);
        step(1'b1, 2'b01, 2'b01);
        step(1'b1, 2'b11, 2'b01);
        step(1'b0, 2'b11, 2'b10);
        step(1'b1, 2'b11, 2'b10);
        step(1'b1, 2'b11, 2'b01);
        // req drop while outstanding
        step(1'b1, 2'b11, 2'b01);
        step(1'b1, 2'b01, 2'b00);
        // long stall: timeout and counter saturation, then sticky flag
        for (int i = 0; i < 40; i++) step(1'b1, 2'b01, 2'b00);
        step(1'b1, 2'b01, 2'b01);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 2'b00);
        step(1'b0, 2'b00, 2'b00);
        step(1'b1, 2'b10, 2'b10);
        for (int i = 0; i < 1500; i++) begin
            logic [NP-1:0] v;
            for (int p = 0; p < NP; p++) v[p] = ($urandom_range(2, 0) == 0);
            step(($urandom_range(59, 0) != 0), NP'($urandom), v);
        end
        @(negedge clk); #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
